// File: rtl/msg_streamer_pkg.sv
// -----------------------------------------------------------------------------
// msg_streamer_pkg
// Shared definitions for the message streamer: default widths, FSM state type,
// per-message length table, ASCII constants and a length lookup helper.
// No ports (package).
// -----------------------------------------------------------------------------
package msg_streamer_pkg;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MSG_DEPTH_DEF = 128;

    // Number of entries in the length table; NUM_MSG may be overridden lower.
    localparam int unsigned MSG_TBL_N = 4;

    // Lengths of "HELLO\n", "OK", "!", "ZACAPA".
    localparam int unsigned MSG_LEN [MSG_TBL_N] = '{6, 2, 1, 6};

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] SP = 8'h20;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Length of message m; 0 for messages outside the table.
    function automatic int unsigned msg_len(input int unsigned m);
        return (m < MSG_TBL_N) ? MSG_LEN[m] : 0;
    endfunction

endpackage

// File: rtl/msg_streamer_rom.sv
// -----------------------------------------------------------------------------
// msg_rom
// Purely combinational character ROM holding the stored messages.
// Ports:
//   msg   in  SEL_W   message number
//   idx   in  IDX_W   character index within the message
//   char  out DATA_W  character at (msg, idx); 0 for unused addresses
// -----------------------------------------------------------------------------
module msg_rom
    import msg_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned IDX_W  = 7
) (
    input  logic [SEL_W-1:0]  msg,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] char
);

    function automatic logic [DATA_W-1:0] ch(input logic [7:0] c);
        return DATA_W'(c);
    endfunction

    always_comb begin
        char = '0;
        case (32'(msg))
            0: begin
                case (32'(idx))
                    0: char = ch("H");
                    1: char = ch("E");
                    2: char = ch("L");
                    3: char = ch("L");
                    4: char = ch("O");
                    5: char = ch(LF);
                    default: char = '0;
                endcase
            end
            1: begin
                case (32'(idx))
                    0: char = ch("O");
                    1: char = ch("K");
                    default: char = '0;
                endcase
            end
            2: begin
                case (32'(idx))
                    0: char = ch("!");
                    default: char = '0;
                endcase
            end
            3: begin
                case (32'(idx))
                    0: char = ch("Z");
                    1: char = ch("A");
                    2: char = ch("C");
                    3: char = ch("A");
                    4: char = ch("P");
                    5: char = ch("A");
                    default: char = '0;
                endcase
            end
            default: char = '0;
        endcase
    end

endmodule

// File: rtl/msg_streamer.sv
// -----------------------------------------------------------------------------
// msg_streamer
// Streams one of NUM_MSG stored ASCII messages, one character per accepted
// valid/ready transfer, in one-shot or loop mode, with abort and
// completion/error pulses.
// Ports:
//   clk        in   1       clock
//   reset      in   1       asynchronous, active-high reset
//   sel        in   SEL_W   message number, sampled when start is accepted
//   start      in   1       begin streaming sel (IDLE only)
//   stop       in   1       abort current stream (wins over start)
//   mode_loop  in   1       1 = restart after the last character
//   out_ready  in   1       consumer accepts out_data
//   out_data   out  DATA_W  current character (registered)
//   out_valid  out  1       out_data valid
//   out_last   out  1       out_data is the final character
//   busy       out  1       high while streaming
//   done       out  1       pulse after a one-shot stream completes
//   err        out  1       pulse on start with sel >= NUM_MSG
// -----------------------------------------------------------------------------
module msg_streamer
    import msg_streamer_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned NUM_MSG   = MSG_TBL_N,
    parameter int unsigned MSG_DEPTH = MSG_DEPTH_DEF,
    parameter int unsigned SEL_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_loop,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDX_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_MSG < 1 || NUM_MSG > MSG_TBL_N) begin : g_bad_num
        $error("msg_streamer: NUM_MSG out of range of the length table");
    end
    if ((1 << SEL_W) < NUM_MSG) begin : g_bad_sel
        $error("msg_streamer: SEL_W too narrow for NUM_MSG");
    end
    for (genvar m = 0; m < NUM_MSG && m < MSG_TBL_N; m++) begin : g_len_chk
        if (MSG_LEN[m] == 0 || MSG_LEN[m] > MSG_DEPTH) begin : g_bad_len
            $error("msg_streamer: message length must be 1..MSG_DEPTH");
        end
    end

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                load;      // present ROM[sel_d][idx_d] next cycle
    logic                go_idle;   // leave STREAM and blank the outputs
    logic                xfer;
    logic [DATA_W-1:0]   rom_char;

    assign xfer = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        load    = 1'b0;
        go_idle = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (32'(sel) < NUM_MSG) begin
                        state_d = STREAM;
                        sel_d   = sel;
                        idx_d   = '0;
                        load    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (stop) begin
                    state_d = IDLE;
                    go_idle = 1'b1;
                end else if (xfer) begin
                    // out_last_q already flags the final character, so no
                    // length compare is needed on the accepting edge.
                    if (out_last_q) begin
                        if (mode_loop) begin
                            idx_d = '0;
                            load  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            go_idle = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                go_idle = 1'b1;
            end
        endcase
    end

    msg_rom #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .IDX_W  (IDX_W)
    ) u_rom (
        .msg  (sel_d),
        .idx  (idx_d),
        .char (rom_char)
    );

    // Output registers are fed from the ROM at the next address, so each
    // accepted character is replaced on the same edge with no bubble.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_data_d  = rom_char;
            out_valid_d = 1'b1;
            out_last_d  = ((32'(idx_d) + 32'd1) == msg_len(32'(sel_d)));
        end else if (go_idle) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == STREAM);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_msg_streamer.sv
module tb_msg_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       start, start3, stop, mode_loop, out_ready;

    logic [7:0] out_data, out_data3;
    logic       out_valid, out_last, busy, done, err;
    logic       out_valid3, out_last3, busy3, done3, err3;

    msg_streamer dut (
        .clk(clk), .reset(reset), .sel(sel), .start(start), .stop(stop),
        .mode_loop(mode_loop), .out_ready(out_ready), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .busy(busy),
        .done(done), .err(err)
    );

    msg_streamer #(.NUM_MSG(3)) dut3 (
        .clk(clk), .reset(reset), .sel(sel), .start(start3), .stop(stop),
        .mode_loop(mode_loop), .out_ready(out_ready), .out_data(out_data3),
        .out_valid(out_valid3), .out_last(out_last3), .busy(busy3),
        .done(done3), .err(err3)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which message is playing and which character is shown.
    string msgs [4];
    bit    m_active;
    int    m_msg, m_pos;
    bit    m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_last();
        return m_active && (m_pos == msgs[m_msg].len() - 1);
    endfunction

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit nd = 1'b0;
        if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_msg    = int'(sel);
                m_pos    = 0;
            end
        end else if (stop) begin
            m_active = 1'b0;
        end else if (out_ready) begin
            if (m_is_last()) begin
                if (mode_loop) m_pos = 0;
                else begin
                    m_active = 1'b0;
                    nd       = 1'b1;
                end
            end else begin
                m_pos++;
            end
        end
        m_done = nd;
    endtask

    task automatic check_all();
        chk("valid", 32'(out_valid), 32'(m_active));
        chk("busy",  32'(busy),      32'(m_active));
        chk("last",  32'(out_last),  32'(m_is_last()));
        chk("done",  32'(done),      32'(m_done));
        chk("err",   32'(err),       32'd0);
        if (m_active) chk("data", 32'(out_data), 32'(msgs[m_msg].getc(m_pos)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    logic [7:0] t1 [6];

    initial begin
        msgs = '{"HELLO\n", "OK", "!", "ZACAPA"};
        t1   = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
        m_active = 1'b0; m_msg = 0; m_pos = 0; m_done = 1'b0;
        reset = 1'b1; sel = '0; start = 1'b0; start3 = 1'b0; stop = 1'b0;
        mode_loop = 1'b0; out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_valid3", 32'(out_valid3), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: one-shot HELLO\n at full rate
        sel = 2'd0; start = 1'b1; out_ready = 1'b1; mode_loop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            chk("t1_data", 32'(out_data), 32'(t1[i]));
            chk("t1_last", 32'(out_last), (i == 5) ? 32'd1 : 32'd0);
        end
        step();
        chk("t1_done",  32'(done),      32'd1);
        chk("t1_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // 2: backpressure on "OK"; sel/mode changes while held must not matter
        sel = 2'd1; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0; sel = 2'd3; mode_loop = 1'b1;
        step();
        chk("t2_hold_O", 32'(out_data), 32'h4F);
        step();
        chk("t2_hold_O2", 32'(out_data), 32'h4F);
        out_ready = 1'b1; mode_loop = 1'b0;
        step();
        chk("t2_K",      32'(out_data), 32'h4B);
        chk("t2_K_last", 32'(out_last), 32'd1);
        step();
        chk("t2_done", 32'(done), 32'd1);

        // 3: single-char message looping, then drop loop mode
        sel = 2'd2; start = 1'b1; mode_loop = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            chk("t3_data", 32'(out_data),  32'h21);
            chk("t3_last", 32'(out_last),  32'd1);
            chk("t3_vld",  32'(out_valid), 32'd1);
        end
        mode_loop = 1'b0;
        step();
        chk("t3_done",  32'(done),      32'd1);
        chk("t3_valid", 32'(out_valid), 32'd0);

        // 4: abort ZACAPA at 'C', then restart with "OK"
        sel = 2'd3; start = 1'b1; mode_loop = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t4_C", 32'(out_data), 32'h43);
        stop = 1'b1;
        step();
        chk("t4_stop_valid", 32'(out_valid), 32'd0);
        chk("t4_stop_busy",  32'(busy),      32'd0);
        chk("t4_stop_done",  32'(done),      32'd0);
        stop = 1'b0; sel = 2'd1; start = 1'b1;
        step();
        chk("t4_restart_O", 32'(out_data), 32'h4F);
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0; mode_loop = 1'b0;

        // 5: NUM_MSG=3 instance: out-of-range select, start+stop, valid start
        sel = 2'd3; start3 = 1'b1;
        step();
        chk("t5_err",   32'(err3),       32'd1);
        chk("t5_valid", 32'(out_valid3), 32'd0);
        chk("t5_busy",  32'(busy3),      32'd0);
        start3 = 1'b0;
        step();
        chk("t5_err_pulse", 32'(err3), 32'd0);
        start3 = 1'b1; start = 1'b1; stop = 1'b1; sel = 2'd1;
        step();
        chk("t5_ss_err",   32'(err3),       32'd0);
        chk("t5_ss_valid", 32'(out_valid3), 32'd0);
        start = 1'b0; stop = 1'b0;
        step();
        start3 = 1'b0;
        chk("t5_ok_valid", 32'(out_valid3), 32'd1);
        chk("t5_ok_data",  32'(out_data3),  32'h4F);
        chk("t5_ok_last",  32'(out_last3),  32'd0);
        chk("t5_ok_done",  32'(done3),      32'd0);
        stop = 1'b1;
        step();
        chk("t5_stop_valid", 32'(out_valid3), 32'd0);
        stop = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 24) == 0);
            sel       = 2'($urandom_range(0, 3));
            mode_loop = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;

        // 6: asynchronous reset in the middle of a stream
        sel = 2'd0; start = 1'b1; out_ready = 1'b1; mode_loop = 1'b1;
        step();
        start = 1'b0;
        step();
        #3 reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data",  32'(out_data),  32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_last",  32'(out_last),  32'd0);
        m_active = 1'b0; m_done = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
